// File: rtl/kamacore_pkg.sv
// kamacore_pkg: shared widths and enums for the kamacore pipeline.
package kamacore_pkg;
    localparam int cpu_width = 32;
    localparam int reg_addr_width = 5;
    typedef enum logic [1:0] {MEM_BYTE = 2'd0, MEM_HALF = 2'd1, MEM_WORD = 2'd2} mem_size_t;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
endpackage

// File: rtl/kamacore_mem_align.sv
// kamacore_mem_align: store lane placement and load extract/extend for the memory stage.
// Misaligned low address bits are aligned down to the access size.
module kamacore_mem_align
    import kamacore_pkg::*;
#(
    parameter int W = cpu_width
) (
    input  mem_size_t    size_i,
    input  logic [1:0]   addr_lo_i,
    input  logic         unsigned_i,
    input  logic [W-1:0] store_data_i,
    input  logic [W-1:0] rdata_i,
    output logic [3:0]   be_o,
    output logic [W-1:0] wdata_o,
    output logic [W-1:0] load_o
);
    logic [1:0]   off;
    logic [W-1:0] shifted;
    always_comb begin
        off = size_i == MEM_BYTE ? addr_lo_i : size_i == MEM_HALF ? {addr_lo_i[1], 1'b0} : 2'b00;
        be_o = size_i == MEM_BYTE ? 4'b0001 << off : size_i == MEM_HALF ? 4'b0011 << off : 4'b1111;
        wdata_o = size_i == MEM_BYTE ? {(W/8){store_data_i[7:0]}} :
                  size_i == MEM_HALF ? {(W/16){store_data_i[15:0]}} : store_data_i;
        shifted = rdata_i >> {off, 3'b000};
        load_o = size_i == MEM_BYTE ? {{(W-8){~unsigned_i & shifted[7]}}, shifted[7:0]} :
                 size_i == MEM_HALF ? {{(W-16){~unsigned_i & shifted[15]}}, shifted[15:0]} : shifted;
    end
endmodule

// File: rtl/kamacore_stage_mem.sv
// kamacore_stage_mem: memory stage issuing req/ack data accesses and registering MEM/WB.
// Optional KAMACORE_MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module kamacore_stage_mem
    import kamacore_pkg::*;
#(
    parameter int CPU_WIDTH      = cpu_width,
    parameter int REG_ADDR_WIDTH = reg_addr_width
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      ex_valid,
    input  logic [CPU_WIDTH-1:0]      ex_alu_result,
    input  logic [CPU_WIDTH-1:0]      ex_read_data_b,
    input  logic [REG_ADDR_WIDTH-1:0] ex_destination_register,
    input  logic                      ex_control_memory_read,
    input  logic                      ex_control_memory_write,
    input  logic [1:0]                ex_mem_size,
    input  logic                      ex_mem_unsigned,
    input  logic                      ex_control_write_rd,
    input  logic                      ex_control_write_register,
    output logic                      mem_busy,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [CPU_WIDTH-1:0]      dmem_addr,
    output logic [CPU_WIDTH-1:0]      dmem_wdata,
    output logic [3:0]                dmem_be,
    input  logic                      dmem_ack,
    input  logic [CPU_WIDTH-1:0]      dmem_rdata,
    output logic [REG_ADDR_WIDTH-1:0] destination_register,
    output logic [CPU_WIDTH-1:0]      read_data_b,
    output logic [CPU_WIDTH-1:0]      data_memory_result,
    output logic                      control_memory_read,
    output logic                      control_write_rd,
    output logic                      control_write_register
`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
    ,
    output logic                      mem_misaligned
`endif
);
    mem_state_t           state_q;
    mem_size_t            size;
    logic                 kill_q, mem_op, mis, issue, cap_en, cap_live;
    logic [3:0]           be;
    logic [CPU_WIDTH-1:0] res_q, wdata, load_data, acc_data, cap_data;

    assign size = mem_size_t'(ex_mem_size);
    assign mem_op = ex_valid & (ex_control_memory_read | ex_control_memory_write);
`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
    assign mis = mem_op & (size == MEM_HALF ? ex_alu_result[0] : size != MEM_BYTE && ex_alu_result[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign issue = state_q == IDLE & mem_op & ~flush & ~mis;
    assign mem_busy = state_q == IDLE ? issue : state_q == WAIT ? ~dmem_ack | hold : hold;
    assign cap_en = state_q == IDLE ? ~issue & ~hold : state_q == WAIT ? dmem_ack & ~hold : ~hold;
    // A flush seen at any point of an outstanding access turns its write-back into a bubble.
    assign cap_live = state_q == IDLE ? ex_valid & ~flush & ~mis : ~(kill_q | flush);
    assign acc_data = ex_control_memory_read & ~ex_control_memory_write ? load_data : ex_alu_result;
    assign cap_data = state_q == IDLE ? ex_alu_result : state_q == WAIT ? acc_data : res_q;

    kamacore_mem_align #(.W(CPU_WIDTH)) u_align (
        .size_i       (size),
        .addr_lo_i    (ex_alu_result[1:0]),
        .unsigned_i   (ex_mem_unsigned),
        .store_data_i (ex_read_data_b),
        .rdata_i      (dmem_rdata),
        .be_o         (be),
        .wdata_o      (wdata),
        .load_o       (load_data)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            kill_q <= 1'b0;
            res_q <= '0;
            dmem_req <= 1'b0;
            dmem_we <= 1'b0;
            dmem_be <= 4'b0000;
            dmem_addr <= '0;
            dmem_wdata <= '0;
            destination_register <= '0;
            read_data_b <= '0;
            data_memory_result <= '0;
            control_memory_read <= 1'b0;
            control_write_rd <= 1'b0;
            control_write_register <= 1'b0;
`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
            mem_misaligned <= 1'b0;
`endif
        end else begin
`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
            mem_misaligned <= cap_en & state_q == IDLE & ex_valid & ~flush & mis;
`endif
            if (cap_en) begin
                destination_register <= ex_destination_register;
                read_data_b <= ex_read_data_b;
                data_memory_result <= cap_data;
                control_memory_read <= ex_control_memory_read & cap_live;
                control_write_rd <= ex_control_write_rd & cap_live;
                control_write_register <= ex_control_write_register & cap_live;
            end
            case (state_q)
                IDLE: if (issue) begin
                    state_q <= WAIT;
                    kill_q <= 1'b0;
                    dmem_req <= 1'b1;
                    dmem_we <= ex_control_memory_write;
                    dmem_addr <= {ex_alu_result[CPU_WIDTH-1:2], 2'b00};
                    dmem_be <= be;
                    dmem_wdata <= wdata;
                end
                WAIT: begin
                    kill_q <= kill_q | flush;
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we <= 1'b0;
                        dmem_be <= 4'b0000;
                        res_q <= acc_data;
                        state_q <= hold ? DONE : IDLE;
                    end
                end
                default: begin
                    kill_q <= kill_q | flush;
                    if (!hold) state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_kamacore_stage_mem.sv
// tb_kamacore_stage_mem: scoreboard bench for the memory stage in its default build.
module tb_kamacore_stage_mem;
    logic        clk = 1'b0;
    logic        clear, hold, flush, ex_valid;
    logic [31:0] ex_alu_result, ex_read_data_b;
    logic [4:0]  ex_destination_register;
    logic        ex_control_memory_read, ex_control_memory_write;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_unsigned, ex_control_write_rd, ex_control_write_register;
    logic        mem_busy, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [4:0]  destination_register;
    logic [31:0] read_data_b, data_memory_result;
    logic        control_memory_read, control_write_rd, control_write_register;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rdb;
        logic [31:0] data;
        logic        mrd, wrd, wreg, bubble;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   n_pass = 0;
    int   n_total = 0;
    int   busy_cnt;

    always #5 clk = ~clk;

    kamacore_stage_mem dut (
        .clk                       (clk),
        .clear                     (clear),
        .hold                      (hold),
        .flush                     (flush),
        .ex_valid                  (ex_valid),
        .ex_alu_result             (ex_alu_result),
        .ex_read_data_b            (ex_read_data_b),
        .ex_destination_register   (ex_destination_register),
        .ex_control_memory_read    (ex_control_memory_read),
        .ex_control_memory_write   (ex_control_memory_write),
        .ex_mem_size               (ex_mem_size),
        .ex_mem_unsigned           (ex_mem_unsigned),
        .ex_control_write_rd       (ex_control_write_rd),
        .ex_control_write_register (ex_control_write_register),
        .mem_busy                  (mem_busy),
        .dmem_req                  (dmem_req),
        .dmem_we                   (dmem_we),
        .dmem_addr                 (dmem_addr),
        .dmem_wdata                (dmem_wdata),
        .dmem_be                   (dmem_be),
        .dmem_ack                  (dmem_ack),
        .dmem_rdata                (dmem_rdata),
        .destination_register      (destination_register),
        .read_data_b               (read_data_b),
        .data_memory_result        (data_memory_result),
        .control_memory_read       (control_memory_read),
        .control_write_rd          (control_write_rd),
        .control_write_register    (control_write_register)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        if (sz == 2'd0) return u ? {24'h0, b} : {{24{b[7]}}, b};
        if (sz == 2'd1) return u ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    task automatic idle_in();
        ex_valid = 1'b0;
        ex_control_memory_read = 1'b0;
        ex_control_memory_write = 1'b0;
        ex_control_write_rd = 1'b0;
        ex_control_write_register = 1'b0;
        flush = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_mrd"}, control_memory_read, e.mrd);
            check({tag, "_wrd"}, control_write_rd, e.wrd);
            check({tag, "_wreg"}, control_write_register, e.wreg);
            if (!e.bubble) begin
                check({tag, "_rd"}, destination_register, e.rd);
                check({tag, "_rdb"}, read_data_b, e.rdb);
                check({tag, "_data"}, data_memory_result, e.data);
                last = e;
            end
        end
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] val, input logic fl);
        sb.push_back('{rd, ~val, val, 1'b0, !fl, !fl, fl});
        @(posedge clk); #1;
        ex_valid = 1'b1;
        ex_destination_register = rd;
        ex_alu_result = val;
        ex_read_data_b = ~val;
        ex_control_write_rd = 1'b1;
        ex_control_write_register = 1'b1;
        flush = fl;
        @(negedge clk);
        check("alu_busy", mem_busy, 32'd0);
        @(posedge clk); #1;
        idle_in();
        pop_check("alu");
    endtask

    task automatic bus_check(input string tag, input logic st, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be);
        check({tag, "_req"}, dmem_req, 32'd1);
        check({tag, "_addr"}, dmem_addr, a);
        check({tag, "_we"}, dmem_we, st);
        if (st) begin
            check({tag, "_be"}, dmem_be, be);
            check({tag, "_wdata"}, dmem_wdata, wd);
        end
    endtask

    task automatic mem_op(input logic [31:0] addr, input logic [31:0] wd, input logic ld, input logic st,
                          input logic [1:0] sz, input logic uns, input logic [4:0] rd, input int dly,
                          input logic [31:0] rdata, input int hold_n, input logic fl,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_res);
        sb.push_back('{rd, wd, exp_res, ld & !fl, !fl, !fl, fl});
        busy_cnt = 0;
        @(posedge clk); #1;
        ex_valid = 1'b1;
        ex_alu_result = addr;
        ex_read_data_b = wd;
        ex_control_memory_read = ld;
        ex_control_memory_write = st;
        ex_mem_size = sz;
        ex_mem_unsigned = uns;
        ex_destination_register = rd;
        ex_control_write_rd = 1'b1;
        ex_control_write_register = 1'b1;
        @(negedge clk);
        check("issue_busy", mem_busy, 32'd1);
        check("issue_req", dmem_req, 32'd0);
        busy_cnt += int'(mem_busy);
        @(posedge clk); #1;
        for (int i = 0; i < dly; i++) begin
            flush = fl && i == 0;
            @(negedge clk);
            bus_check("wait", st, exp_addr, exp_wdata, exp_be);
            check("wait_busy", mem_busy, 32'd1);
            busy_cnt += int'(mem_busy);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        hold = hold_n > 0;
        @(negedge clk);
        bus_check("ack", st, exp_addr, exp_wdata, exp_be);
        check("ack_busy", mem_busy, 32'(hold_n > 0));
        busy_cnt += int'(mem_busy);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'hDEAD_BEEF;
        if (hold_n > 0) begin
            for (int i = 1; i < hold_n; i++) begin
                @(negedge clk);
                check("done_req", dmem_req, 32'd0);
                check("done_busy", mem_busy, 32'd1);
                check("done_keep_data", data_memory_result, last.data);
                check("done_keep_rd", destination_register, last.rd);
                @(posedge clk); #1;
            end
            hold = 1'b0;
            @(negedge clk);
            check("done_release_busy", mem_busy, 32'd0);
            @(posedge clk); #1;
        end
        idle_in();
        check("req_drop", dmem_req, 32'd0);
        pop_check("mem");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, rdata;
        logic [1:0]  sz;
        logic        u;
        clear = 1'b1;
        hold = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        ex_alu_result = '0;
        ex_read_data_b = '0;
        ex_destination_register = '0;
        ex_mem_size = '0;
        ex_mem_unsigned = 1'b0;
        idle_in();
        last = '{5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd", destination_register, 32'd0);
        check("rst_data", data_memory_result, 32'd0);
        check("rst_wreg", control_write_register, 32'd0);
        check("rst_req", dmem_req, 32'd0);
        check("rst_be", dmem_be, 32'd0);
        check("rst_busy", mem_busy, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;

        alu_op(5'd7, 32'h1234, 1'b0);
        mem_op(32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd5, 0, 32'h80AABBCC, 0, 1'b0,
               32'h100, 32'h0, 4'h0, 32'hFFFFFF80);
        mem_op(32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 5'd5, 0, 32'h80AABBCC, 0, 1'b0,
               32'h100, 32'h0, 4'h0, 32'h00000080);
        mem_op(32'h22, 32'hBEEF, 1'b0, 1'b1, 2'd1, 1'b0, 5'd2, 3, 32'h0, 0, 1'b0,
               32'h20, 32'hBEEFBEEF, 4'b1100, 32'h22);
        check("store_busy_cycles", busy_cnt, 32'd4);
        mem_op(32'h42, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd4, 0, 32'h80010000, 2, 1'b0,
               32'h40, 32'h0, 4'h0, 32'hFFFF8001);
        mem_op(32'h101, 32'hA7, 1'b0, 1'b1, 2'd0, 1'b0, 5'd6, 2, 32'h0, 0, 1'b1,
               32'h100, 32'hA7A7A7A7, 4'b0010, 32'h101);
        alu_op(5'd3, 32'h55, 1'b1);
        alu_op(5'd8, 32'h77, 1'b0);

        sb.push_back('{5'd9, ~32'h99, 32'h99, 1'b0, 1'b1, 1'b1, 1'b0});
        @(posedge clk); #1;
        ex_valid = 1'b1;
        ex_destination_register = 5'd9;
        ex_alu_result = 32'h99;
        ex_read_data_b = ~32'h99;
        ex_control_write_rd = 1'b1;
        ex_control_write_register = 1'b1;
        hold = 1'b1;
        @(negedge clk);
        check("hold_idle_busy", mem_busy, 32'd0);
        @(posedge clk); #1;
        check("hold_keep_rd", destination_register, last.rd);
        check("hold_keep_data", data_memory_result, last.data);
        hold = 1'b0;
        @(posedge clk); #1;
        idle_in();
        pop_check("hold_idle");

        mem_op(32'h304, 32'h11223344, 1'b0, 1'b1, 2'd2, 1'b0, 5'd10, 1, 32'h0, 0, 1'b0,
               32'h304, 32'h11223344, 4'b1111, 32'h304);
        for (int i = 0; i < 6; i++) begin
            a = 32'h200 + 32'($urandom_range(0, 3));
            rdata = $urandom;
            sz = 2'($urandom_range(0, 2));
            u = 1'($urandom_range(0, 1));
            mem_op(a, 32'h0, 1'b1, 1'b0, sz, u, 5'(11 + i), $urandom_range(0, 2), rdata, 0, 1'b0,
                   32'h200, 32'h0, 4'h0, ref_load(rdata, a[1:0], sz, u));
        end

        @(posedge clk); #1;
        ex_valid = 1'b1;
        ex_alu_result = 32'h80;
        ex_control_memory_read = 1'b1;
        ex_mem_size = 2'd2;
        ex_destination_register = 5'd20;
        ex_control_write_register = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("clr_pre_req", dmem_req, 32'd1);
        @(posedge clk); #1;
        clear = 1'b1;
        idle_in();
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_req", dmem_req, 32'd0);
        check("clr_we", dmem_we, 32'd0);
        check("clr_be", dmem_be, 32'd0);
        check("clr_busy", mem_busy, 32'd0);
        check("clr_rd", destination_register, 32'd0);
        check("clr_data", data_memory_result, 32'd0);
        check("clr_rdb", read_data_b, 32'd0);
        check("clr_mrd", control_memory_read, 32'd0);
        check("clr_wreg", control_write_register, 32'd0);
        alu_op(5'd7, 32'hCAFE, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/kamacore_stage_mem.md
Name: kamacore_stage_mem

Overview:
- Memory stage of the kamacore pipeline.
- Consumes EX/MEM pipeline fields and performs data-memory loads and stores over a req/ack bus.
- Aligns, sign- or zero-extends load data and registers the MEM/WB fields: destination_register, read_data_b, data_memory_result, control_memory_read, control_write_rd, control_write_register.
- Stalls upstream while an access is outstanding.

Parameters:
- CPU_WIDTH, 32, datapath and address width in bits.
- REG_ADDR_WIDTH, 5, register-index width in bits.

Ports:
- clk  input  1  pipeline clock
- clear  input  1  reset; synchronous, active-high
- hold  input  1  global pipeline stall; MEM/WB outputs freeze
- flush  input  1  kill the instruction currently in this stage
- ex_valid  input  1  EX/MEM holds a real instruction
- ex_alu_result  input  CPU_WIDTH  address for memory ops, result otherwise
- ex_read_data_b  input  CPU_WIDTH  store data
- ex_destination_register  input  REG_ADDR_WIDTH  rd
- ex_control_memory_read  input  1  load
- ex_control_memory_write  input  1  store
- ex_mem_size  input  2  0 byte, 1 half, 2 word
- ex_mem_unsigned  input  1  zero-extend load
- ex_control_write_rd  input  1  passthrough
- ex_control_write_register  input  1  passthrough
- mem_busy  output  1  upstream must hold EX/MEM this cycle
- dmem_req  output  1  bus request
- dmem_we  output  1  write strobe
- dmem_addr  output  CPU_WIDTH  word-aligned address (low 2 bits zero)
- dmem_wdata  output  CPU_WIDTH  lane-replicated store data
- dmem_be  output  4  byte enables
- dmem_ack  input  1  access complete; dmem_rdata valid this cycle
- dmem_rdata  input  CPU_WIDTH  read word
- destination_register, read_data_b, data_memory_result, control_memory_read, control_write_rd, control_write_register  output  as MEM/WB  registered MEM/WB fields

Behaviour:
- All flops update on rising clk; clear (synchronous, active-high) wins over everything.
- On clear: state=IDLE; all MEM/WB outputs 0; dmem_req/dmem_we/dmem_be 0.
- On clear mid-access: the request is abandoned; the bus shares clear.
- Bubble: control_memory_read=control_write_rd=control_write_register=0.
- FSM states:
  - IDLE: no access outstanding.
  - WAIT: dmem_req=1 with latched addr/we/be/wdata; these are held stable until dmem_ack.
  - DONE: ack received under hold; result buffered.
- IDLE, non-memory op (or !ex_valid):
  - if !hold, MEM/WB captures next edge; data_memory_result=ex_alu_result.
  - !ex_valid or flush captures a bubble.
  - mem_busy=0. Latency 1 cycle.
- IDLE, valid load/store, !flush:
  - mem_busy=1 combinationally.
  - Latch the request; go to WAIT. MEM/WB is unchanged.
- WAIT:
  - mem_busy = !dmem_ack | hold.
  - On ack & !hold: MEM/WB captures; loads take extracted data, stores take ex_alu_result; next state IDLE.
  - On ack & hold: buffer the result; go to DONE.
- DONE:
  - mem_busy=1 while hold.
  - When !hold: MEM/WB captures the buffer, mem_busy=0, go to IDLE.
- Minimum memory-op latency: arrival N, req N+1, ack N+1, MEM/WB valid at edge N+2.
- flush during WAIT/DONE: the access runs to ack (no cancel); the result is discarded and a bubble is written. Flush is remembered in a sticky bit until completion.
- hold in IDLE: MEM/WB unchanged; a memory op may still issue (go to WAIT).
- Store lanes:
  - byte: be=0001<<addr[1:0], wdata=4x byte.
  - half: be=0011<<(2*addr[1]), wdata=2x half.
  - word: be=1111.
- Load extract: rdata>>(8*addr[1:0]), truncate to size, sign-extend unless ex_mem_unsigned.
- Load and store both asserted: treated as a store; control_memory_read passes through unchanged.

Optional Feature:
- Macro: KAMACORE_MEM_MISALIGN_TRAP_EN.
- When defined:
  - Adds output mem_misaligned (1 bit, registered, reset 0).
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no request.
  - Such an access takes 1 cycle, writes a bubble and pulses mem_misaligned for one cycle with the MEM/WB capture.
- When undefined: the port is absent; misaligned low address bits are ignored (aligned down to the access size).

Decomposition:
- kamacore_pkg holds:
  - cpu_width and reg_addr_width constants.
  - mem_size_t enum (MEM_BYTE, MEM_HALF, MEM_WORD).
  - mem_state_t enum (IDLE, WAIT, DONE).
- Sub-module kamacore_mem_align (combinational) generates be/wdata and performs load extract/extend.

Test Plan:
- ALU op with rd=7, alu_result=0x1234, no hold -> next edge destination_register=7, data_memory_result=0x1234, control_write_register=1, mem_busy never high.
- Signed byte load at addr 0x103, rdata=0x80AABBCC, ack same cycle as req -> dmem_addr=0x100, data_memory_result=0xFFFFFF80 at edge N+2; with ex_mem_unsigned -> 0x00000080.
- Half store of 0xBEEF at addr 0x22, ack delayed 3 cycles -> dmem_be=1100, dmem_wdata=0xBEEFBEEF held stable, mem_busy high for 4 cycles, dmem_req drops after ack.
- Load with ack arriving while hold=1 for 2 cycles -> state DONE; MEM/WB unchanged until hold falls, then captures the buffered data.
- flush asserted in WAIT of a store -> dmem_req stays until ack; then a bubble (all control bits 0).
- clear asserted in WAIT -> next edge dmem_req=0, all outputs 0, state IDLE.
